// File: rtl/frame_seq_pkg.sv
// Shared types and elaboration helpers for the frame BRAM sequencer.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int frame_pix(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_rd_skid.sv
// Two-entry skid FIFO holding BRAM read results (data plus eol/eof tags).
module frame_rd_skid #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_idx;
    logic         rd_idx;

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_idx <= ~wr_idx;
            if (pop)  rd_idx <= ~rd_idx;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

    assign head = mem[rd_idx];

endmodule

// File: rtl/bram_frame_sequencer.sv
// Fills one frame BRAM from a pixel stream, then drains it in raster order
// with backpressure and line/frame markers.
module bram_frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic              CLK_IN1,
    input  logic              RESET,
    input  logic              start,
    input  logic              rd_only,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              enb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb
);

    localparam int N     = frame_pix(IMG_W, IMG_H);
    localparam int PTR_W = ptr_width(N);
    localparam int X_W   = ptr_width(IMG_W);
    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(N - 1);
    localparam logic [X_W-1:0]   LAST_X    = X_W'(IMG_W - 1);

    if (N > 2 ** ADDR_W) begin : g_size_check
        $error("IMG_W*IMG_H does not fit in the BRAM address space");
    end

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              rd_all;
    logic [X_W-1:0]    x_cnt;
    logic              inflight, inflight_eol, inflight_eof;
    logic              wr_accept, rd_issue, pop, eof_pop;
    logic [1:0]        fifo_count, occ_next;
    logic [DATA_W+1:0] head;

    assign wr_accept = in_valid && (state == ST_FILL);
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign eof_pop   = pop && head[0];
    // Credit check looks at occupancy after this cycle's push and pop.
    assign occ_next  = fifo_count + {1'b0, inflight} - {1'b0, pop};
    assign rd_issue  = (state == ST_DRAIN) && !rd_all && (occ_next < 2'd2);

    assign out_data = out_valid ? head[DATA_W+1:2] : '0;
    assign out_eol  = out_valid && head[1];
    assign out_eof  = out_valid && head[0];

    always_ff @(posedge CLK_IN1) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        ena       = 1'b0;
        wea       = 1'b0;
        addra     = '0;
        dina      = '0;
        enb       = 1'b0;
        addrb     = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = rd_only ? ST_DRAIN : ST_FILL;
            end
            ST_FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (wr_accept) begin
                    ena   = 1'b1;
                    wea   = 1'b1;
                    addra = ADDR_W'(wr_ptr);
                    dina  = in_data;
                    if (wr_ptr == LAST_ADDR) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (rd_issue) begin
                    enb   = 1'b1;
                    addrb = ADDR_W'(rd_ptr);
                end
                if (eof_pop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN1) begin
        if (RESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_all       <= 1'b0;
            x_cnt        <= '0;
            inflight     <= 1'b0;
            inflight_eol <= 1'b0;
            inflight_eof <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            if (rd_issue) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
                rd_all <= (rd_ptr == LAST_ADDR);
                x_cnt  <= (x_cnt == LAST_X) ? '0 : x_cnt + 1'b1;
            end
            // Tags travel with the read so they line up with doutb next cycle.
            inflight     <= rd_issue;
            inflight_eol <= (x_cnt == LAST_X);
            inflight_eof <= (rd_ptr == LAST_ADDR);
            done         <= eof_pop;
            if (eof_pop) begin
                rd_ptr <= '0;
                rd_all <= 1'b0;
                x_cnt  <= '0;
            end
        end
    end

    frame_rd_skid #(
        .W(DATA_W + 2)
    ) u_skid (
        .clk       (CLK_IN1),
        .rst       (RESET),
        .push      (inflight),
        .push_data ({doutb, inflight_eol, inflight_eof}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

endmodule
